// File: rtl/motor_pkg.sv
// motor_pkg: shared state encoding and constants for the stepper axis generator
package motor_pkg;
  typedef enum logic [1:0] {S_IDLE, S_DIR_SETUP, S_STEP_HIGH, S_STEP_LOW} state_t;
  localparam logic DIR_POS = 1'b1;
  localparam int COUNT_W = 32;
endpackage

// File: rtl/motor_step_timer.sv
// motor_step_timer: loadable down-counter, o_done while the count sits at zero
module motor_step_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_done
);
  logic [W-1:0] r_count;
  always_ff @(posedge clk)
    r_count <= rst ? '0 : i_load ? i_load_val : r_count - W'(r_count != '0);
  assign o_done = r_count == '0;
endmodule

// File: rtl/motor_step_generator.sv
// motor_step_generator: turns a magnitude/direction command into STEP/DIR pulses for one axis
module motor_step_generator
  import motor_pkg::*;
#(
  parameter int STEP_PERIOD = 5000,
  parameter int PULSE_HIGH  = 100,
  parameter int DIR_SETUP   = 20
) (
  input  logic               PCLK,
  input  logic               PRESET,
  input  logic [COUNT_W-1:0] cmd_count,
  input  logic               cmd_dir,
  output logic [COUNT_W-1:0] count_out,
  output logic               dir_out,
  output logic               step,
  output logic               dir,
  output logic               busy
);
  localparam int TW = $clog2((STEP_PERIOD > DIR_SETUP ? STEP_PERIOD : DIR_SETUP) + 1);
  state_t r_state, w_next;
  logic [COUNT_W-1:0] r_count, w_count, r_pend_count;
  logic [COUNT_W:0] r_last_cmd;
  logic r_pend_dir, r_pend_valid, r_dir, w_dir, r_step;
  logic w_new, w_done, w_apply;
  logic [TW-1:0] w_load_val;
  assign w_new = {cmd_dir, cmd_count} != r_last_cmd;
  // Commands only take effect between whole pulses, never mid high or low phase
  assign w_apply = r_pend_valid && (r_state == S_IDLE || (r_state == S_STEP_LOW && w_done));
  always_comb begin
    w_next = r_state;
    w_count = r_count;
    w_dir = r_dir;
    case (r_state)
      S_DIR_SETUP: w_next = w_done ? S_STEP_HIGH : r_state;
      S_STEP_HIGH: begin
        w_next = w_done ? S_STEP_LOW : r_state;
        w_count = w_done ? r_count - COUNT_W'(r_count != '0) : r_count;
      end
      S_STEP_LOW: w_next = !w_done ? r_state : r_count == '0 ? S_IDLE : S_STEP_HIGH;
      default: w_next = r_state;
    endcase
    if (w_apply) begin
      w_count = r_pend_count;
      w_dir = r_pend_count == '0 ? r_dir : r_pend_dir;
      w_next = r_pend_count == '0 ? S_IDLE : r_pend_dir != r_dir ? S_DIR_SETUP : S_STEP_HIGH;
    end
  end
  assign w_load_val = w_next == S_DIR_SETUP ? TW'(DIR_SETUP - 1)
                    : w_next == S_STEP_HIGH ? TW'(PULSE_HIGH - 1)
                    : w_next == S_STEP_LOW  ? TW'(STEP_PERIOD - PULSE_HIGH - 1) : '0;
  motor_step_timer #(.W(TW)) u_timer (
    .clk(PCLK),
    .rst(PRESET),
    .i_load(w_next != r_state),
    .i_load_val(w_load_val),
    .o_done(w_done)
  );
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_dir <= DIR_POS;
      r_step <= 1'b0;
      r_last_cmd <= {DIR_POS, COUNT_W'(0)};
      r_pend_valid <= 1'b0;
      r_pend_count <= '0;
      r_pend_dir <= DIR_POS;
    end else begin
      r_state <= w_next;
      r_count <= w_count;
      r_dir <= w_dir;
      r_step <= w_next == S_STEP_HIGH;
      r_last_cmd <= {cmd_dir, cmd_count};
      r_pend_valid <= w_new || (r_pend_valid && !w_apply);
      if (w_new) begin
        r_pend_count <= cmd_count;
        r_pend_dir <= cmd_dir;
      end
    end
  end
  assign count_out = r_count;
  assign dir_out = r_dir;
  assign dir = r_dir;
  assign step = r_step;
  assign busy = r_state != S_IDLE;
endmodule
